// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned multiplier that drives an external ALU's 32-bit adder.
// Each RUN step may add the shifted multiplicand into the accumulator through
// the ALU. An optional FLAG pass writes the product's flags into the ALU.
module alu_mul_sequencer #(
  parameter int          OP_W       = 16,
  parameter logic [4:0]  FUNSEL_ADD = 5'b10100
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic [OP_W-1:0] OpA,
  input  logic [OP_W-1:0] OpB,
  input  logic            SetFlags,
  output logic            Busy,
  output logic            Done,
  output logic [31:0]     Product,
  output logic [31:0]     AluA,
  output logic [31:0]     AluB,
  output logic [4:0]      AluFunSel,
  output logic            AluWF,
  input  logic [31:0]     AluOut
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FLAG = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [31:0]       p_reg;     // accumulator
  logic [31:0]       m_reg;     // multiplicand, shifted left each step
  logic [OP_W-1:0]   q_reg;     // multiplier, shifted right each step
  logic [4:0]        cnt_reg;   // completed step count
  logic              sf_reg;    // SetFlags captured with Start

  logic              accept;
  logic              last_step;

  // A Start is taken in IDLE and also in DONE, which gives back-to-back operation.
  assign accept    = Start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign last_step = (cnt_reg == 5'(OP_W - 1));

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic; no early exit, RUN always takes OP_W steps.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN:  if (last_step) state_next = sf_reg ? ST_FLAG : ST_DONE;
      ST_FLAG: state_next = ST_DONE;
      ST_DONE: state_next = accept ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: ALU operands come from the accumulator datapath.
  always_comb begin
    Busy      = 1'b0;
    Done      = 1'b0;
    AluA      = 32'd0;
    AluB      = 32'd0;
    AluWF     = 1'b0;
    AluFunSel = FUNSEL_ADD;
    case (state_reg)
      ST_RUN: begin
        Busy = 1'b1;
        AluA = p_reg;
        AluB = m_reg;
      end
      ST_FLAG: begin
        Busy  = 1'b1;
        AluA  = p_reg;
        AluWF = 1'b1;
      end
      ST_DONE: Done = 1'b1;
      default: ;
    endcase
  end

  // Shift-add datapath. Operands are latched only on acceptance, so later
  // changes to OpA/OpB/SetFlags, or a Start while busy, have no effect.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      p_reg   <= 32'd0;
      m_reg   <= 32'd0;
      q_reg   <= '0;
      cnt_reg <= 5'd0;
      sf_reg  <= 1'b0;
    end else if (accept) begin
      p_reg   <= 32'd0;
      m_reg   <= {{(32-OP_W){1'b0}}, OpA};
      q_reg   <= OpB;
      cnt_reg <= 5'd0;
      sf_reg  <= SetFlags;
    end else if (state_reg == ST_RUN) begin
      if (q_reg[0]) p_reg <= AluOut;
      m_reg   <= m_reg << 1;
      q_reg   <= q_reg >> 1;
      cnt_reg <= cnt_reg + 5'd1;
    end
  end

  // Result register, loaded on the edge that enters DONE. Coming straight from
  // RUN, the final step's add is still in flight, so it is taken from AluOut.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Product <= 32'd0;
    end else if ((state_reg == ST_RUN) && last_step && !sf_reg) begin
      Product <= q_reg[0] ? AluOut : p_reg;
    end else if (state_reg == ST_FLAG) begin
      Product <= p_reg;
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural stand-in for the ALU
// adder and its {Z,C,N,O} flag register.
`timescale 1ns/1ps
module tb_alu_mul_sequencer;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] OpA = 16'd0;
  logic [15:0] OpB = 16'd0;
  logic        SetFlags = 1'b0;
  logic        Busy, Done, AluWF;
  logic [31:0] Product, AluA, AluB, AluOut;
  logic [4:0]  AluFunSel;

  logic [3:0]  flags = 4'b0000;
  logic        preset_en = 1'b0;
  logic [3:0]  preset_val = 4'b0000;

  int n_checks = 0;
  int n_fails  = 0;
  int edges;
  int wf_cycles;
  int done_seen;

  alu_mul_sequencer dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .OpA(OpA), .OpB(OpB),
    .SetFlags(SetFlags), .Busy(Busy), .Done(Done), .Product(Product),
    .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF), .AluOut(AluOut)
  );

  always #5 Clock = ~Clock;

  // ALU stand-in: combinational add, flag register written when WF is high.
  assign AluOut = AluA + AluB;
  always @(posedge Clock) begin
    if (preset_en)  flags <= preset_val;
    else if (AluWF) flags <= {(AluOut == 32'd0), 1'b0, AluOut[31], 1'b0};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic preset_flags(input logic [3:0] v);
    @(negedge Clock);
    preset_val = v;
    preset_en  = 1'b1;
    tick();
    preset_en  = 1'b0;
  endtask

  // Wait (bounded) for Done; counts edges since acceptance into 'edges'.
  task automatic wait_done(input string tag, input int start_edge);
    edges = start_edge;
    while (!Done && edges < 60) begin
      tick();
      edges++;
      if (AluWF) wf_cycles++;
    end
    if (!Done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Issue one operation and check latency, product, WF pulse count and flags.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sf, input logic [31:0] exp_p, input int exp_lat,
                        input logic [3:0] exp_flags);
    @(negedge Clock);
    Start = 1'b1; OpA = a; OpB = b; SetFlags = sf;
    tick();                 // edge 0: accepted
    Start = 1'b0; OpA = 16'hDEAD; OpB = 16'hBEEF; SetFlags = ~sf;
    wf_cycles = 0;
    tick();                 // edge 1
    check({tag, "_busy"}, 32'(Busy), 32'd1);
    wait_done(tag, 1);
    check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    check({tag, "_product"}, Product, exp_p);
    check({tag, "_wf_cycles"}, 32'(wf_cycles), sf ? 32'd1 : 32'd0);
    check({tag, "_flags"}, 32'(flags), 32'(exp_flags));
    tick();
    check({tag, "_done_pulse"}, 32'(Done), 32'd0);
  endtask

  initial begin
    // 1. Asynchronous reset between edges
    tick(); tick();
    #2 Reset_n = 1'b0;
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_product", Product, 32'd0);
    check("rst_alua", AluA, 32'd0);
    check("rst_alub", AluB, 32'd0);
    check("rst_wf", 32'(AluWF), 32'd0);
    check("rst_funsel", 32'(AluFunSel), 32'h14);
    @(negedge Clock);
    Reset_n = 1'b1;

    // 2. Plain multiply, flags untouched
    preset_flags(4'b1111);
    run_op("t2", 16'h1234, 16'h0010, 1'b0, 32'h0001_2340, 16, 4'b1111);

    // 3. Max operands with flag pass
    run_op("t3", 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001, 17, 4'b0010);

    // 4. Zero product sets Z
    run_op("t4", 16'h0000, 16'hABCD, 1'b1, 32'h0000_0000, 17, 4'b1000);

    // 5. Start while busy ignored; Start in DONE accepted
    @(negedge Clock);
    Start = 1'b1; OpA = 16'h0003; OpB = 16'h0005; SetFlags = 1'b0;
    tick();                 // edge 0
    Start = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    @(negedge Clock);
    Start = 1'b1; OpA = 16'h00FF; OpB = 16'h00FF;
    tick();                 // edge 5
    Start = 1'b0;
    wait_done("t5a", 5);
    check("t5a_latency", 32'(edges), 32'd16);
    check("t5a_product", Product, 32'h0000_000F);
    Start = 1'b1; OpA = 16'h0002; OpB = 16'h0007;   // inside the DONE cycle
    tick();
    Start = 1'b0;
    wait_done("t5b", 0);
    check("t5b_latency", 32'(edges), 32'd16);
    check("t5b_product", Product, 32'h0000_000E);

    // 6. Reset mid-operation aborts, then a fresh operation completes
    preset_flags(4'b0101);
    @(negedge Clock);
    Start = 1'b1; OpA = 16'h1234; OpB = 16'h5678; SetFlags = 1'b1;
    tick();                 // edge 0
    Start = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    Reset_n = 1'b0;
    #1;
    check("t6_busy", 32'(Busy), 32'd0);
    check("t6_product", Product, 32'd0);
    check("t6_wf", 32'(AluWF), 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Done) done_seen++;
    end
    check("t6_no_done", 32'(done_seen), 32'd0);
    check("t6_product_hold", Product, 32'd0);
    check("t6_flags", 32'(flags), 32'h5);
    run_op("t6b", 16'h1234, 16'h5678, 1'b0, 32'h0626_0060, 16, 4'b0101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
